// File: rtl/mpeg_pkg.sv
// mpeg_pkg: shared widths and the buffer entry type for the MPEG ES packer.
package mpeg_pkg;

    localparam int unsigned ES_WORD_W = 32;
    localparam int unsigned DTS_W     = 33;

    // One buffered output word together with its framing and DTS tag.
    typedef struct packed {
        logic [ES_WORD_W-1:0]    data;
        logic [2:0]              nbytes;
        logic                    last;
        logic signed [DTS_W-1:0] dts;
        logic                    dts_valid;
    } es_entry_t;

endpackage

// File: rtl/mpeg_es_fifo.sv
// mpeg_es_fifo: synchronous show-ahead FIFO of es_entry_t with a registered
// head. A word written into an empty buffer appears at the head one edge later.
module mpeg_es_fifo
    import mpeg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  es_entry_t                     push_entry,
    input  logic                          pop,
    output logic                          full,
    output es_entry_t                     head,
    output logic                          head_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    es_entry_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Push is qualified by the level before any same-edge pop.
    always_comb begin
        full    = (level == DEPTH_L);
        do_push = push & ~full;
        do_pop  = pop & head_valid;
    end

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Head register mirrors mem[rd_ptr]; on a pop it prefetches the next entry
    // when one was already stored, so back-to-back pops run at full rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            head_valid <= 1'b0;
        end else if (do_pop) begin
            if (level >= LW'(2)) begin
                head       <= mem[rd_ptr + AW'(1)];
                head_valid <= 1'b1;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (!head_valid && level != '0) begin
            head       <= mem[rd_ptr];
            head_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mpeg_es_packer.sv
// mpeg_es_packer: packs selected PES payload bytes big-endian into 32-bit
// words, flushes partial words on end-of-program and buffers them in
// mpeg_es_fifo. Define MPEG_ES_DTS_TAG_EN to tag words with the latest DTS.
module mpeg_es_packer
    import mpeg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    mpeg_data,
    input  logic                          data_valid,
    input  logic                          mpeg_packet_body,
    input  logic                          event_program_end,
    input  logic signed [DTS_W-1:0]       decoding_timestamp,
    input  logic                          decoding_timestamp_updated,
    output logic [ES_WORD_W-1:0]          es_word,
    output logic [2:0]                    es_nbytes,
    output logic                          es_last,
    output logic                          es_valid,
    input  logic                          es_ready,
    output logic signed [DTS_W-1:0]       es_dts,
    output logic                          es_dts_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    logic [1:0]             byte_cnt;
    logic [ES_WORD_W-1:0]   sreg;
    logic                   accept;
    logic [2:0]             cat_cnt;
    logic [ES_WORD_W-1:0]   cat_sreg;
    logic [ES_WORD_W-1:0]   aligned;
    logic                   push_req;
    logic                   fifo_full;
    logic                   tag_valid;
    logic signed [DTS_W-1:0] tag_dts;
    es_entry_t              push_entry;
    es_entry_t              head;
    logic                   head_valid;

    // Fold in this edge's byte first, then decide whether a word leaves.
    always_comb begin
        accept   = data_valid & mpeg_packet_body;
        cat_cnt  = {1'b0, byte_cnt} + {2'b00, accept};
        cat_sreg = accept ? {sreg[23:0], mpeg_data} : sreg;
        push_req = (accept && byte_cnt == 2'd3) ||
                   (event_program_end && cat_cnt != 3'd0);
        case (cat_cnt)
            3'd1:    aligned = {cat_sreg[7:0],  24'h0};
            3'd2:    aligned = {cat_sreg[15:0], 16'h0};
            3'd3:    aligned = {cat_sreg[23:0], 8'h0};
            default: aligned = cat_sreg;
        endcase
        push_entry.data      = aligned;
        push_entry.nbytes    = cat_cnt;
        push_entry.last      = event_program_end;
        push_entry.dts       = tag_dts;
        push_entry.dts_valid = tag_valid;
    end

    // Byte accumulator and sticky drop flag; any push (kept or dropped) restarts the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            sreg     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req) begin
                byte_cnt <= '0;
                sreg     <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                sreg     <= cat_sreg;
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MPEG_ES_DTS_TAG_EN
    logic signed [DTS_W-1:0] dts_lat;
    logic                    dts_pend;

    // Latest DTS and whether it still awaits a stored word.
    always_ff @(posedge clk) begin
        if (reset) begin
            dts_lat  <= '0;
            dts_pend <= 1'b0;
        end else begin
            if (decoding_timestamp_updated) begin
                dts_lat <= decoding_timestamp;
            end
            if (push_req && !fifo_full) begin
                dts_pend <= 1'b0;
            end else if (decoding_timestamp_updated) begin
                dts_pend <= 1'b1;
            end
        end
    end

    // A same-edge update tags the word being pushed on that edge.
    always_comb begin
        tag_valid = decoding_timestamp_updated | dts_pend;
        tag_dts   = decoding_timestamp_updated ? decoding_timestamp : dts_lat;
    end

    // DTS outputs come straight from the head entry, held at zero in reset.
    always_comb begin
        es_dts       = reset ? '0 : head.dts;
        es_dts_valid = reset ? 1'b0 : head.dts_valid;
    end
`else
    logic unused_dts;

    // Tagging disabled: constant-zero tag so no DTS bits carry state.
    always_comb begin
        tag_valid    = 1'b0;
        tag_dts      = '0;
        es_dts       = '0;
        es_dts_valid = 1'b0;
        unused_dts   = ^{decoding_timestamp, decoding_timestamp_updated,
                         head.dts, head.dts_valid};
    end
`endif

    mpeg_es_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_req),
        .push_entry (push_entry),
        .pop        (es_ready),
        .full       (fifo_full),
        .head       (head),
        .head_valid (head_valid),
        .level      (fifo_level)
    );

    // Output word fields, forced to zero while reset is asserted.
    always_comb begin
        es_valid  = reset ? 1'b0 : head_valid;
        es_word   = reset ? '0 : head.data;
        es_nbytes = reset ? '0 : head.nbytes;
        es_last   = reset ? 1'b0 : head.last;
    end

endmodule
